branch_dest_sequencer: RTL and testbench

Controller that sequences the branch-destination address register of the soft CPU. It arbitrates between three redirect sources: trap, jump and taken branch. For the winner it drives the register's D and ClockEnable, pulses a pipeline flush, then presents the new target to the fetch stage over a valid/ready handshake. It sits between the execute-stage branch/jump logic and the fetch unit, on the same Clock/Tick domain as the register it drives.

---
 rtl/branch_dest_sequencer_if.sv | 36 +++
 rtl/branch_dest_sequencer.sv | 116 +++++++++++
 tb/tb_branch_dest_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_dest_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_dest_sequencer_if                                               |
// | Redirect request bus (execute -> sequencer) and redirect offer to fetch |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
interface branch_dest_sequencer_if #(
  parameter int NrOfBits = 32
);
  logic                TrapReq;
  logic                JumpReq;
  logic [NrOfBits-1:0] JumpAddr;
  logic                BranchReq;
  logic                BranchTaken;
  logic [NrOfBits-1:0] BranchAddr;
  logic                RedirectReady;
  logic [2:0]          Grant;
  logic                Misalign;
  logic                Flush;
  logic [NrOfBits-1:0] RegD;
  logic                RegLoad;
  logic                RedirectValid;
  logic [NrOfBits-1:0] RedirectAddr;
  logic                Busy;

  modport master (
    input  TrapReq, JumpReq, JumpAddr, BranchReq, BranchTaken, BranchAddr, RedirectReady,
    output Grant, Misalign, Flush, RegD, RegLoad, RedirectValid, RedirectAddr, Busy
  );

  modport slave (
    output TrapReq, JumpReq, JumpAddr, BranchReq, BranchTaken, BranchAddr, RedirectReady,
    input  Grant, Misalign, Flush, RegD, RegLoad, RedirectValid, RedirectAddr, Busy
  );
endinterface
`default_nettype wire

// File: rtl/branch_dest_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_dest_sequencer                                                  |
// | Arbitrates trap/jump/branch redirects, loads the destination register, |
// | flushes the pipeline and offers the target to fetch.                   |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module branch_dest_sequencer #(
  parameter int                  NrOfBits   = 32,
  parameter logic [NrOfBits-1:0] TrapVector = NrOfBits'(32'h0000_0004)
) (
  input wire logic                Clock,
  input wire logic                Reset,
  input wire logic                Tick,
  branch_dest_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic c_trap_misalign = (TrapVector[1:0] != 2'b00);

  state_t              r_state, w_state_nxt;
  logic [NrOfBits-1:0] r_pending, w_pending_nxt;
  logic [2:0]          r_grant, w_grant_nxt;
  logic                r_flush, w_flush_nxt;
  logic                r_misalign, w_misalign_nxt;
  logic [2:0]          w_win;
  logic [NrOfBits-1:0] w_sel;
  logic                w_sel_misalign;

  // Fixed priority: trap > jump > taken branch
  always_comb begin
    w_win = 3'b000;
    w_sel = TrapVector;
    if (bus.TrapReq) begin
      w_win = 3'b100;
      w_sel = TrapVector;
    end else if (bus.JumpReq) begin
      w_win = 3'b010;
      w_sel = bus.JumpAddr;
    end else if (bus.BranchReq && bus.BranchTaken) begin
      w_win = 3'b001;
      w_sel = bus.BranchAddr;
    end
    w_sel_misalign = (w_sel[1:0] != 2'b00);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_grant_nxt    = r_grant;
    w_flush_nxt    = r_flush;
    w_misalign_nxt = r_misalign;
    // Pulse registers only retire on a Tick cycle so each pulse is one Tick wide
    if (Tick) begin
      w_grant_nxt    = 3'b000;
      w_flush_nxt    = 1'b0;
      w_misalign_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win != 3'b000) begin
            w_pending_nxt  = w_sel_misalign ? TrapVector : w_sel;
            w_grant_nxt    = w_win;
            w_flush_nxt    = 1'b1;
            w_misalign_nxt = w_sel_misalign;
            w_state_nxt    = ST_LOAD;
          end
        end
        ST_LOAD: w_state_nxt = ST_ISSUE;
        ST_ISSUE: begin
          if (bus.RedirectReady) begin
            w_state_nxt = ST_IDLE;
          end else if (bus.TrapReq) begin
            w_pending_nxt  = TrapVector;
            w_grant_nxt    = 3'b100;
            w_flush_nxt    = 1'b1;
            w_misalign_nxt = c_trap_misalign;
            w_state_nxt    = ST_LOAD;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_grant    <= 3'b000;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_grant    <= w_grant_nxt;
      r_flush    <= w_flush_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign bus.Grant         = Tick ? r_grant : 3'b000;
  assign bus.Flush         = Tick & r_flush;
  assign bus.Misalign      = Tick & r_misalign;
  assign bus.RegLoad       = Tick && (r_state == ST_LOAD);
  assign bus.RegD          = r_pending;
  assign bus.RedirectValid = (r_state == ST_ISSUE);
  assign bus.RedirectAddr  = r_pending;
  assign bus.Busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_branch_dest_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_branch_dest_sequencer                                               |
// | Directed scenarios plus randomized run against a behavioural model.    |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module tb_branch_dest_sequencer;

  localparam logic [31:0] c_TV = 32'h0000_0004;
  // ctl = {Grant[2:0], Flush, Misalign, RegLoad, RedirectValid, Busy}
  localparam logic [7:0] c_IDLE   = 8'b000_00000;
  localparam logic [7:0] c_GJ     = 8'b010_10101;
  localparam logic [7:0] c_GT     = 8'b100_10101;
  localparam logic [7:0] c_GB_MIS = 8'b001_11101;
  localparam logic [7:0] c_ISS    = 8'b000_00011;
  localparam logic [7:0] c_STALL  = 8'b000_00001;

  logic Clock, Reset, Tick;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_dest_sequencer_if #(.NrOfBits(32)) bus ();

  branch_dest_sequencer #(.NrOfBits(32), .TrapVector(c_TV)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bus   (bus)
  );

  logic [7:0]  ctl;
  logic [71:0] obs;
  assign ctl = {bus.Grant, bus.Flush, bus.Misalign, bus.RegLoad, bus.RedirectValid, bus.Busy};
  assign obs = {ctl, bus.RegD, bus.RedirectAddr};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick_clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic quiet_inputs();
    Reset = 1'b0; Tick = 1'b1;
    bus.TrapReq = 1'b0; bus.JumpReq = 1'b0; bus.JumpAddr = '0;
    bus.BranchReq = 1'b0; bus.BranchTaken = 1'b0; bus.BranchAddr = '0;
    bus.RedirectReady = 1'b1;
  endtask

  task automatic do_reset();
    quiet_inputs();
    Reset = 1'b1;
    tick_clk();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    Reset = 1'b1; bus.JumpReq = 1'b1; bus.JumpAddr = 32'h300;
    tick_clk();
    Reset = 1'b0; bus.JumpReq = 1'b0;
    n_cmp++; if (obs !== {c_IDLE, 32'h0, 32'h0}) begin n_err++; $display("FAIL reset_state: got %h expected %h", obs, {c_IDLE, 32'h0, 32'h0}); end
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, 32'h0, 32'h0}) begin n_err++; $display("FAIL reset_jump_ignored: got %h expected %h", obs, {c_IDLE, 32'h0, 32'h0}); end
  endtask

  task automatic test_jump_basic();
    do_reset();
    bus.JumpReq = 1'b1; bus.JumpAddr = 32'h100; bus.RedirectReady = 1'b1;
    tick_clk();
    bus.JumpReq = 1'b0;
    n_cmp++; if (obs !== {c_GJ, 32'h100, 32'h100}) begin n_err++; $display("FAIL jump_grant: got %h expected %h", obs, {c_GJ, 32'h100, 32'h100}); end
    tick_clk();
    n_cmp++; if (obs !== {c_ISS, 32'h100, 32'h100}) begin n_err++; $display("FAIL jump_issue: got %h expected %h", obs, {c_ISS, 32'h100, 32'h100}); end
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, 32'h100, 32'h100}) begin n_err++; $display("FAIL jump_idle: got %h expected %h", obs, {c_IDLE, 32'h100, 32'h100}); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.TrapReq = 1'b1; bus.JumpReq = 1'b1; bus.JumpAddr = 32'h200;
    bus.BranchReq = 1'b1; bus.BranchTaken = 1'b1; bus.BranchAddr = 32'h300;
    tick_clk();
    bus.TrapReq = 1'b0; bus.BranchReq = 1'b0; bus.BranchTaken = 1'b0;
    n_cmp++; if (obs !== {c_GT, c_TV, c_TV}) begin n_err++; $display("FAIL prio_trap_grant: got %h expected %h", obs, {c_GT, c_TV, c_TV}); end
    tick_clk();
    n_cmp++; if (obs !== {c_ISS, c_TV, c_TV}) begin n_err++; $display("FAIL prio_trap_issue: got %h expected %h", obs, {c_ISS, c_TV, c_TV}); end
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, c_TV, c_TV}) begin n_err++; $display("FAIL prio_idle_after_accept: got %h expected %h", obs, {c_IDLE, c_TV, c_TV}); end
    tick_clk();
    bus.JumpReq = 1'b0;
    n_cmp++; if (obs !== {c_GJ, 32'h200, 32'h200}) begin n_err++; $display("FAIL prio_held_jump: got %h expected %h", obs, {c_GJ, 32'h200, 32'h200}); end
    tick_clk();
    tick_clk();
  endtask

  task automatic test_branch();
    do_reset();
    bus.BranchReq = 1'b1; bus.BranchTaken = 1'b0; bus.BranchAddr = 32'h40;
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, 32'h0, 32'h0}) begin n_err++; $display("FAIL branch_not_taken: got %h expected %h", obs, {c_IDLE, 32'h0, 32'h0}); end
    bus.BranchTaken = 1'b1; bus.BranchAddr = 32'h42;
    tick_clk();
    bus.BranchReq = 1'b0; bus.BranchTaken = 1'b0;
    n_cmp++; if (obs !== {c_GB_MIS, c_TV, c_TV}) begin n_err++; $display("FAIL branch_misalign_grant: got %h expected %h", obs, {c_GB_MIS, c_TV, c_TV}); end
    tick_clk();
    n_cmp++; if (obs !== {c_ISS, c_TV, c_TV}) begin n_err++; $display("FAIL branch_misalign_issue: got %h expected %h", obs, {c_ISS, c_TV, c_TV}); end
    tick_clk();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.RedirectReady = 1'b0; bus.JumpReq = 1'b1; bus.JumpAddr = 32'h80;
    tick_clk();
    bus.JumpReq = 1'b0;
    n_cmp++; if (obs !== {c_GJ, 32'h80, 32'h80}) begin n_err++; $display("FAIL bp_grant: got %h expected %h", obs, {c_GJ, 32'h80, 32'h80}); end
    for (int k = 0; k < 5; k++) begin
      tick_clk();
      n_cmp++; if (obs !== {c_ISS, 32'h80, 32'h80}) begin n_err++; $display("FAIL bp_hold_%0d: got %h expected %h", k, obs, {c_ISS, 32'h80, 32'h80}); end
    end
    bus.TrapReq = 1'b1;
    tick_clk();
    bus.TrapReq = 1'b0;
    n_cmp++; if (obs !== {c_GT, c_TV, c_TV}) begin n_err++; $display("FAIL bp_preempt_grant: got %h expected %h", obs, {c_GT, c_TV, c_TV}); end
    tick_clk();
    n_cmp++; if (obs !== {c_ISS, c_TV, c_TV}) begin n_err++; $display("FAIL bp_preempt_issue: got %h expected %h", obs, {c_ISS, c_TV, c_TV}); end
    bus.RedirectReady = 1'b1;
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, c_TV, c_TV}) begin n_err++; $display("FAIL bp_accept: got %h expected %h", obs, {c_IDLE, c_TV, c_TV}); end
  endtask

  task automatic test_tick_stall();
    do_reset();
    bus.JumpReq = 1'b1; bus.JumpAddr = 32'h1C0; bus.RedirectReady = 1'b1;
    tick_clk();
    bus.JumpReq = 1'b0; Tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (obs !== {c_STALL, 32'h1C0, 32'h1C0}) begin n_err++; $display("FAIL stall_load_%0d: got %h expected %h", k, obs, {c_STALL, 32'h1C0, 32'h1C0}); end
      tick_clk();
    end
    Tick = 1'b1; #1;
    n_cmp++; if (obs !== {c_GJ, 32'h1C0, 32'h1C0}) begin n_err++; $display("FAIL stall_release: got %h expected %h", obs, {c_GJ, 32'h1C0, 32'h1C0}); end
    tick_clk();
    Tick = 1'b0;
    tick_clk();
    n_cmp++; if (obs !== {c_ISS, 32'h1C0, 32'h1C0}) begin n_err++; $display("FAIL stall_no_handshake: got %h expected %h", obs, {c_ISS, 32'h1C0, 32'h1C0}); end
    Tick = 1'b1;
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, 32'h1C0, 32'h1C0}) begin n_err++; $display("FAIL stall_handshake: got %h expected %h", obs, {c_IDLE, 32'h1C0, 32'h1C0}); end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    bus.RedirectReady = 1'b0; bus.JumpReq = 1'b1; bus.JumpAddr = 32'h80;
    tick_clk();
    bus.JumpReq = 1'b0;
    tick_clk();
    n_cmp++; if (obs !== {c_ISS, 32'h80, 32'h80}) begin n_err++; $display("FAIL rst_mid_pre: got %h expected %h", obs, {c_ISS, 32'h80, 32'h80}); end
    Reset = 1'b1; bus.JumpReq = 1'b1; bus.JumpAddr = 32'h300;
    tick_clk();
    Reset = 1'b0; bus.JumpReq = 1'b0;
    n_cmp++; if (obs !== {c_IDLE, 32'h0, 32'h0}) begin n_err++; $display("FAIL rst_mid_clear: got %h expected %h", obs, {c_IDLE, 32'h0, 32'h0}); end
    tick_clk();
    n_cmp++; if (obs !== {c_IDLE, 32'h0, 32'h0}) begin n_err++; $display("FAIL rst_mid_no_grant: got %h expected %h", obs, {c_IDLE, 32'h0, 32'h0}); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  // Model: one redirect at a time; 0 = free, 1 = register load due, 2 = offered to fetch
  task automatic test_random();
    int          phase = 0;
    logic [31:0] pend = '0;
    logic [2:0]  g = '0;
    logic        f = 1'b0, m = 1'b0;
    logic [2:0]  win;
    logic [31:0] sel;
    logic [7:0]  exp_ctl;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Reset             = ($urandom_range(0, 49) == 0);
      Tick              = ($urandom_range(0, 3) != 0);
      bus.TrapReq       = ($urandom_range(0, 9) == 0);
      bus.JumpReq       = ($urandom_range(0, 3) == 0);
      bus.BranchReq     = ($urandom_range(0, 2) == 0);
      bus.BranchTaken   = ($urandom_range(0, 1) == 1);
      bus.JumpAddr      = rand_addr();
      bus.BranchAddr    = rand_addr();
      bus.RedirectReady = ($urandom_range(0, 1) == 1);
      #1;
      exp_ctl = {Tick ? g : 3'b000, Tick & f, Tick & m, Tick && (phase == 1), phase == 2, phase != 0};
      n_cmp++; if (ctl !== exp_ctl) begin n_err++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl); end
      n_cmp++; if ({bus.RegD, bus.RedirectAddr} !== {pend, pend}) begin n_err++; $display("FAIL rand_addr[%0d]: got %h/%h expected %h", i, bus.RegD, bus.RedirectAddr, pend); end
      if (Reset) begin
        phase = 0; pend = '0; g = '0; f = 1'b0; m = 1'b0;
      end else if (Tick) begin
        g = '0; f = 1'b0; m = 1'b0;
        win = bus.TrapReq ? 3'b100 : bus.JumpReq ? 3'b010 : (bus.BranchReq && bus.BranchTaken) ? 3'b001 : 3'b000;
        sel = bus.TrapReq ? c_TV : bus.JumpReq ? bus.JumpAddr : bus.BranchAddr;
        if (phase == 0) begin
          if (win != 3'b000) begin
            m = (sel % 4) != 0; pend = m ? c_TV : sel; g = win; f = 1'b1; phase = 1;
          end
        end else if (phase == 1) begin
          phase = 2;
        end else if (bus.RedirectReady) begin
          phase = 0;
        end else if (bus.TrapReq) begin
          pend = c_TV; g = 3'b100; f = 1'b1; phase = 1;
        end
      end
      tick_clk();
    end
  endtask

  initial begin
    quiet_inputs();
    test_reset();
    test_jump_basic();
    test_priority();
    test_branch();
    test_backpressure();
    test_tick_stall();
    test_reset_mid_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
